// File: rtl/game_controller.sv
// game_controller: whack-a-mole round sequencer with countdown, scoring and high score
module game_controller #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int READY_SECONDS = 3,
  parameter int SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_hit,
  input  logic               i_timer_game_over,
  output logic               o_restart_timer,
  output logic               o_mole_enable,
  output logic [1:0]         o_state,
  output logic [1:0]         o_ready_count,
  output logic [SCORE_W-1:0] o_score,
  output logic [SCORE_W-1:0] o_high_score,
  output logic               o_new_record
);
  localparam int TW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  typedef enum logic [1:0] {IDLE, READY, PLAY, OVER} state_t;
  state_t state, state_n;
  logic [TW-1:0] tick, tick_n;
  logic [1:0] cnt_n;
  logic [SCORE_W-1:0] score_n, high_n;
  logic rec_n, restart_n, mole_n;
  assign o_state = state;
  // register every output so downstream logic sees glitch-free values
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state           <= IDLE;
      tick            <= '0;
      o_ready_count   <= '0;
      o_score         <= '0;
      o_high_score    <= '0;
      o_new_record    <= 1'b0;
      o_restart_timer <= 1'b0;
      o_mole_enable   <= 1'b0;
    end else begin
      state           <= state_n;
      tick            <= tick_n;
      o_ready_count   <= cnt_n;
      o_score         <= score_n;
      o_high_score    <= high_n;
      o_new_record    <= rec_n;
      o_restart_timer <= restart_n;
      o_mole_enable   <= mole_n;
    end
  end
  // next state and next output values; game_over is stale while the restart pulse is out
  always_comb begin
    state_n   = state;
    tick_n    = tick;
    cnt_n     = o_ready_count;
    score_n   = o_score;
    high_n    = o_high_score;
    rec_n     = o_new_record;
    restart_n = 1'b0;
    case (state)
      IDLE, OVER: if (i_start) begin
        tick_n  = '0;
        score_n = '0;
        rec_n   = 1'b0;
        if (READY_SECONDS == 0) begin
          state_n   = PLAY;
          cnt_n     = 2'd0;
          restart_n = 1'b1;
        end else begin
          state_n = READY;
          cnt_n   = 2'(READY_SECONDS);
        end
      end
      READY: if (tick == TICK_LAST) begin
        tick_n = '0;
        cnt_n  = o_ready_count - 2'd1;
        if (o_ready_count == 2'd1) begin
          state_n   = PLAY;
          restart_n = 1'b1;
        end
      end else begin
        tick_n = tick + 1'b1;
      end
      PLAY: begin
        score_n = (i_hit && o_score != SCORE_MAX) ? o_score + 1'b1 : o_score;
        if (i_timer_game_over && !o_restart_timer) begin
          state_n = OVER;
          rec_n   = score_n > o_high_score;
          high_n  = rec_n ? score_n : o_high_score;
        end
      end
      default: ;
    endcase
    mole_n = state_n == PLAY;
  end
endmodule
